// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus between the fetch sequencer
// and the instruction memory.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : fetch address (master -> slave)
//   imem_gnt    : request accepted (slave -> master)
//   imem_rvalid : response valid (slave -> master)
//   imem_rdata  : fetched word (slave -> master)
//   imem_err    : access fault, qualified by imem_rvalid (slave -> master)
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  imem_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output imem_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the multicycle RISC-V core. Runs the instruction-memory
// handshake, holds the fetched word for decode/execute, and computes the next
// PC (sequential, redirect, trap vector, mret) at commit. Misaligned redirect
// targets and fetch access faults are redirected to mtvec with a fault pulse.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   bus              : instruction-memory bus (master side)
//   pc               : current program counter
//   pc_ld, pc_data   : next-PC load strobe and value (combinational)
//   instr_valid      : instr holds a word awaiting commit
//   instr            : registered instruction word
//   commit           : current instruction finished (sampled in HOLD only)
//   redirect, redirect_addr : taken branch/jump and its target
//   trap, mret       : trap entry / return, qualified by commit
//   mtvec, mepc      : trap vector base and trap return address
//   fault, fault_cause, fault_addr : fetch-side exception report (combinational)
module fetch_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus,
  input  logic [31:0]  pc,
  output logic         pc_ld,
  output logic [31:0]  pc_data,
  output logic         instr_valid,
  output logic [31:0]  instr,
  input  logic         commit,
  input  logic         redirect,
  input  logic [31:0]  redirect_addr,
  input  logic         trap,
  input  logic         mret,
  input  logic [31:0]  mtvec,
  input  logic [31:0]  mepc,
  output logic         fault,
  output logic [1:0]   fault_cause,
  output logic [31:0]  fault_addr
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK   = 32'hFFFF_FFFC;
  localparam logic [1:0]      CAUSE_MISAL = 2'd0;
  localparam logic [1:0]      CAUSE_ACCESS = 2'd1;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e          state;
  state_e          next_state;
  logic            req_q;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] mepc_word;
  logic            redirect_misal;
  logic            rsp_ok;

  assign mtvec_base     = mtvec & WORD_MASK;
  assign mepc_word      = mepc & WORD_MASK;
  assign redirect_misal = ALIGN_CHECK && (redirect_addr[1:0] != 2'b00);
  assign rsp_ok         = bus.imem_rvalid && !bus.imem_err;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The grant only counts once the request is actually
  // driven, which keeps the first post-reset cycle from advancing.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_REQ: begin
        if (req_q && bus.imem_gnt) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) next_state = bus.imem_err ? ST_REQ : ST_HOLD;
      end
      ST_HOLD: begin
        if (commit) next_state = ST_REQ;
      end
      default: next_state = ST_REQ;
    endcase
  end

  // Next-PC selection and fault reporting.
  always_comb begin
    pc_ld       = 1'b0;
    pc_data     = '0;
    fault       = 1'b0;
    fault_cause = '0;
    fault_addr  = '0;
    unique case (state)
      ST_WAIT: begin
        if (bus.imem_rvalid && bus.imem_err) begin
          pc_ld       = 1'b1;
          pc_data     = mtvec_base;
          fault       = 1'b1;
          fault_cause = CAUSE_ACCESS;
          fault_addr  = pc;
        end
      end
      ST_HOLD: begin
        if (commit) begin
          pc_ld = 1'b1;
          if (trap) begin
            pc_data = mtvec_base;
          end else if (mret) begin
            pc_data = mepc_word;
          end else if (redirect) begin
            if (redirect_misal) begin
              pc_data     = mtvec_base;
              fault       = 1'b1;
              fault_cause = CAUSE_MISAL;
              fault_addr  = redirect_addr;
            end else begin
              pc_data = redirect_addr;
            end
          end else begin
            pc_data = pc + XLEN'(4);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Request and valid flags track the next state; request stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      req_q       <= (next_state == ST_REQ);
      instr_valid <= (next_state == ST_HOLD);
    end
  end

  // Instruction capture on a clean response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
    end else if (state == ST_WAIT && rsp_ok) begin
      instr <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        commit, redirect, trap, mret;
  logic [31:0] redirect_addr, mtvec, mepc;

  logic        a_pc_ld, b_pc_ld, a_instr_valid, b_instr_valid;
  logic [31:0] a_pc_data, b_pc_data, a_instr, b_instr;
  logic        a_fault, b_fault;
  logic [1:0]  a_cause, b_cause;
  logic [31:0] a_faddr, b_faddr;

  int n_tests;
  int n_fail;

  fetch_ctrl_if bus_a ();
  fetch_ctrl_if bus_b ();

  assign bus_a.imem_gnt    = gnt;
  assign bus_a.imem_rvalid = rvalid;
  assign bus_a.imem_rdata  = rdata;
  assign bus_a.imem_err    = err;
  assign bus_b.imem_gnt    = gnt;
  assign bus_b.imem_rvalid = rvalid;
  assign bus_b.imem_rdata  = rdata;
  assign bus_b.imem_err    = err;

  fetch_ctrl #(.ALIGN_CHECK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master), .pc(pc),
    .pc_ld(a_pc_ld), .pc_data(a_pc_data),
    .instr_valid(a_instr_valid), .instr(a_instr),
    .commit(commit), .redirect(redirect), .redirect_addr(redirect_addr),
    .trap(trap), .mret(mret), .mtvec(mtvec), .mepc(mepc),
    .fault(a_fault), .fault_cause(a_cause), .fault_addr(a_faddr)
  );

  fetch_ctrl #(.ALIGN_CHECK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master), .pc(pc),
    .pc_ld(b_pc_ld), .pc_data(b_pc_data),
    .instr_valid(b_instr_valid), .instr(b_instr),
    .commit(commit), .redirect(redirect), .redirect_addr(redirect_addr),
    .trap(trap), .mret(mret), .mtvec(mtvec), .mepc(mepc),
    .fault(b_fault), .fault_cause(b_cause), .fault_addr(b_faddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    pc = 32'h8000_0000;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    commit = 1'b0; redirect = 1'b0; trap = 1'b0; mret = 1'b0;
    redirect_addr = '0;
    mtvec = 32'h8000_1001;
    mepc  = 32'h8000_0203;

    // In reset
    step(); step();
    check("rst_req",   32'(bus_a.imem_req), 32'd0);
    check("rst_pcld",  32'(a_pc_ld), 32'd0);
    check("rst_fault", 32'(a_fault), 32'd0);
    check("rst_valid", 32'(a_instr_valid), 32'd0);
    check("rst_instr", a_instr, 32'h0000_0013);

    // Release and fetch the first word
    @(negedge clk);
    rst_n = 1'b1;
    gnt   = 1'b1;
    step();
    check("c1_req",  32'(bus_a.imem_req), 32'd1);
    check("c1_addr", bus_a.imem_addr, 32'h8000_0000);
    check("c1_pcld", 32'(a_pc_ld), 32'd0);
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
    #1;
    check("wait_req",  32'(bus_a.imem_req), 32'd0);
    check("wait_pcld", 32'(a_pc_ld), 32'd0);
    step();
    rvalid = 1'b0; rdata = '0;
    #1;
    check("c3_valid", 32'(a_instr_valid), 32'd1);
    check("c3_instr", a_instr, 32'h0050_0093);
    check("c3_req",   32'(bus_a.imem_req), 32'd0);

    // HOLD: next-PC selection, combinational
    pc = 32'h8000_0004;
    #1;
    check("nocommit_pcld", 32'(a_pc_ld), 32'd0);
    check("nocommit_data", a_pc_data, 32'd0);
    commit = 1'b1;
    #1;
    check("seq_pcld",  32'(a_pc_ld), 32'd1);
    check("seq_data",  a_pc_data, 32'h8000_0008);
    check("seq_fault", 32'(a_fault), 32'd0);
    pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_data", a_pc_data, 32'h0000_0000);
    redirect = 1'b1; redirect_addr = 32'h8000_0102;
    #1;
    check("misal_a_data",  a_pc_data, 32'h8000_1000);
    check("misal_a_fault", 32'(a_fault), 32'd1);
    check("misal_a_cause", 32'(a_cause), 32'd0);
    check("misal_a_addr",  a_faddr, 32'h8000_0102);
    check("misal_b_data",  b_pc_data, 32'h8000_0102);
    check("misal_b_fault", 32'(b_fault), 32'd0);
    redirect_addr = 32'h8000_0100;
    #1;
    check("redir_data",  a_pc_data, 32'h8000_0100);
    check("redir_fault", 32'(a_fault), 32'd0);
    redirect_addr = 32'h8000_0102;
    trap = 1'b1; mret = 1'b1;
    #1;
    check("all_data",  a_pc_data, 32'h8000_1000);
    check("all_fault", 32'(a_fault), 32'd0);
    trap = 1'b0;
    #1;
    check("mret_data",  a_pc_data, 32'h8000_0200);
    check("mret_fault", 32'(a_fault), 32'd0);
    check("mret_b_data", b_pc_data, 32'h8000_0200);
    mret = 1'b0; redirect = 1'b0;
    pc = 32'h8000_0004;
    #1;
    check("hold_valid", 32'(a_instr_valid), 32'd1);

    // Commit sequential; the core loads the new PC at this edge
    step();
    commit = 1'b0;
    pc = 32'h8000_0008;
    #1;
    check("post_valid", 32'(a_instr_valid), 32'd0);
    check("post_req",   32'(bus_a.imem_req), 32'd1);
    check("post_addr",  bus_a.imem_addr, 32'h8000_0008);
    check("post_instr", a_instr, 32'h0050_0093);

    // Grant withheld; commit and rvalid must be ignored in REQ
    commit = 1'b1; trap = 1'b1; rvalid = 1'b1; err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nogrant_req",   32'(bus_a.imem_req), 32'd1);
      check("nogrant_pcld",  32'(a_pc_ld), 32'd0);
      check("nogrant_fault", 32'(a_fault), 32'd0);
      step();
    end
    commit = 1'b0; trap = 1'b0; rvalid = 1'b0; err = 1'b0;

    // Access fault in WAIT
    pc = 32'h8000_0010;
    gnt = 1'b1;
    step();
    gnt = 1'b0; rvalid = 1'b1; err = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    check("err_pcld",  32'(a_pc_ld), 32'd1);
    check("err_data",  a_pc_data, 32'h8000_1000);
    check("err_fault", 32'(a_fault), 32'd1);
    check("err_cause", 32'(a_cause), 32'd1);
    check("err_addr",  a_faddr, 32'h8000_0010);
    step();
    rvalid = 1'b0; err = 1'b0;
    pc = 32'h8000_1000;
    #1;
    check("err_valid", 32'(a_instr_valid), 32'd0);
    check("err_instr", a_instr, 32'h0050_0093);
    check("err_req",   32'(bus_a.imem_req), 32'd1);

    // Reset pulse in WAIT; the late response must be ignored
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    #1;
    check("w2_req", 32'(bus_a.imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(bus_a.imem_req), 32'd0);
    check("mid_rst_valid", 32'(a_instr_valid), 32'd0);
    check("mid_rst_instr", a_instr, 32'h0000_0013);
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    check("late_pcld", 32'(a_pc_ld), 32'd0);
    step();
    check("late_valid", 32'(a_instr_valid), 32'd0);
    check("late_instr", a_instr, 32'h0000_0013);
    check("late_req",   32'(bus_a.imem_req), 32'd1);
    step();
    check("late2_valid", 32'(a_instr_valid), 32'd0);
    check("late2_instr", a_instr, 32'h0000_0013);
    rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the multicycle RISC-V core. It owns the program counter's load port and computes the next PC (sequential, branch/jump redirect, trap vector, mret) at each instruction commit. It runs the instruction-memory request/grant/response handshake and holds the fetched instruction stable for the decode/execute FSM. It detects instruction-address-misaligned targets and fetch access faults and redirects to `mtvec` on both.

## Interface
- `ALIGN_CHECK`, 1: 1 = a redirect target with `[1:0]!=0` raises a misaligned fault; 0 = no alignment check, target loaded as given.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pc` in 32: current program counter value.
- `pc_ld` out 1: load strobe to the program counter.
- `pc_data` out 32: next-PC value, valid when `pc_ld`=1.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_gnt` in 1: memory accepted the request.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: fetched word.
- `imem_err` in 1: access fault; qualified by `imem_rvalid`.
- `instr_valid` out 1: `instr` holds a fetched instruction awaiting commit.
- `instr` out 32: registered instruction word.
- `commit` in 1: core finished the current instruction; sampled only in HOLD.
- `redirect` in 1: taken branch or jump; qualified by `commit`.
- `redirect_addr` in 32: branch/jump target.
- `trap` in 1: ecall, ebreak, illegal instruction or interrupt; qualified by `commit`.
- `mret` in 1: return from trap; qualified by `commit`.
- `mtvec` in 32: trap vector base; bits [1:0] are ignored and forced to 0.
- `mepc` in 32: trap return address.
- `fault` out 1: one-cycle pulse when a fetch-side exception is raised.
- `fault_cause` out 2: 0 = instruction-address-misaligned, 1 = instruction access fault.
- `fault_addr` out 32: faulting address, to be written to `mtval`/`mepc` by the CSR file.

## Operation
- States: REQ, WAIT, HOLD. Reset state is REQ.
- REQ: `imem_req`=1. On `imem_gnt`=1 go to WAIT; otherwise stay in REQ.
- WAIT: `imem_req`=0.
  - `imem_rvalid`=1 and `imem_err`=0: capture `imem_rdata` into `instr`, go to HOLD.
  - `imem_rvalid`=1 and `imem_err`=1: `pc_ld`=1, `pc_data`=`{mtvec[31:2],2'b00}`, `fault`=1, `fault_cause`=1, `fault_addr`=`pc`. Go to REQ. `instr` is unchanged.
- HOLD: `instr_valid`=1. On `commit`=1, `pc_ld`=1 and the FSM goes to REQ. `pc_data` is chosen by priority:
  1. `trap` → `{mtvec[31:2],2'b00}`
  2. `mret` → `mepc`
  3. `redirect` → `redirect_addr`
  4. otherwise → `pc+4`, mod 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- Misaligned redirect: applies when `ALIGN_CHECK`=1, `redirect` is selected and `redirect_addr[1:0]!=0`.
  - `pc_data`=mtvec, `fault`=1, `fault_cause`=0, `fault_addr`=`redirect_addr`.
  - `mret` to a misaligned `mepc` is not checked; `mepc[1:0]` is cleared.
- `commit`, `redirect`, `trap` and `mret` are ignored in REQ and WAIT. `imem_rvalid` is ignored outside WAIT.
- `pc_ld`, `pc_data`, `fault`, `fault_cause` and `fault_addr` are combinational from the state and inputs. When `pc_ld`=0: `pc_data`=0, `fault`=0, `fault_cause`=0, `fault_addr`=0.

## Timing
- Reset values: state=REQ, `instr`=0x0000_0013 (nop), `instr_valid`=0.
  - While `rst_n`=0: `pc_ld`=0 and `fault`=0.
  - `imem_req`=1 from the first clock edge after `rst_n` rises. The request is not asserted while in reset.
- Reset mid-operation (any state) returns to REQ immediately. An outstanding memory response arriving after reset is ignored because the FSM is in REQ.
- Fetch latency: REQ with `imem_gnt`=1 at edge N, then WAIT; `imem_rvalid` at edge N+k; `instr_valid`=1 from edge N+k+1.
- Minimum loop is 3 cycles per instruction: REQ → WAIT → HOLD → REQ, with the new `pc` visible in the first REQ cycle.
- A commit in the HOLD cycle at edge M: the program counter loads at edge M, and the next cycle issues `imem_req` with `imem_addr` equal to the new PC.
- `instr` and `instr_valid` stay stable for the whole HOLD period; `instr_valid` falls on the edge that leaves HOLD.
- Simultaneous `trap`, `mret` and `redirect`: resolved by the priority order above; only one `fault` pulse is ever produced per cycle.

## Test plan
- Reset release with `pc`=0x8000_0000, `gnt`=1, `rvalid` one cycle later with data 0x0050_0093: `imem_req` in cycle 1, `instr_valid`=1 in cycle 3 with `instr`=0x0050_0093.
- HOLD, `commit`=1 with no other flags, `pc`=0x8000_0004: `pc_ld`=1, `pc_data`=0x8000_0008. With `pc`=0xFFFF_FFFC: `pc_data`=0.
- `commit`+`redirect` with `redirect_addr`=0x8000_0102 and `mtvec`=0x8000_1001:
  - with `ALIGN_CHECK`=1: `pc_data`=0x8000_1000, `fault`=1, `cause`=0, `fault_addr`=0x8000_0102;
  - with `ALIGN_CHECK`=0: `pc_data`=0x8000_0102, `fault`=0.
- `commit` with `trap`, `mret` and `redirect` all set: `pc_data`=mtvec. With `mret`+`redirect`: `pc_data`=`mepc`.
- `imem_err`=1 with `rvalid` for `pc`=0x8000_0010: `fault`=1, `cause`=1, `fault_addr`=0x8000_0010, `pc_data`=mtvec, no `instr_valid`.
- Grant withheld for 5 cycles: `imem_req` stays 1 and `pc_ld` stays 0. `rst_n` pulsed low in WAIT: state returns to REQ, `instr_valid`=0, and a late `rvalid` is ignored.
